// File: rtl/aska_spi_rw.sv
// ----------------------------------------------------------------------------
// aska_spi_rw
//
// Mode-0 SPI slave holding NREG configuration registers of DW bits each.
// Several dies share one SPI master; a die only responds to frames whose
// header IC field matches its IC_addr strap.
//
// Frame: 8-bit header then DW data bits, MSB first (8+DW clocks).
//   header[7 -: IDW]  IC address
//   header[7-IDW]     RW (1 = read)
//   header[AW-1:0]    register address
//   other bits        reserved, ignored
//
// Writes commit on the rising edge of the last data bit, entirely in the
// SPI_Clk domain, and flip wr_toggle so a downstream block can resynchronise
// the event into its own clock. Reads return the addressed register on
// SPI_MISO during the data phase, gated onto the pad by SPI_MISO_oe.
//
// Ports:
//   resetn       async active-low reset (clears registers too)
//   SPI_Clk      SPI clock, sample on rising edge, launch on falling edge
//   SPI_CS       chip select, active-low; high asynchronously clears the frame
//   SPI_MOSI     serial data in
//   IC_addr      strap address of this die
//   SPI_MISO     serial read data
//   SPI_MISO_oe  pad output enable for SPI_MISO
//   regs         all registers, flat, register k at [k*DW +: DW]
//   wr_addr      address of the last committed write
//   wr_toggle    inverts once per committed write
// ----------------------------------------------------------------------------
module aska_spi_rw #(
    parameter int DW   = 32,
    parameter int NREG = 4,
    parameter int AW   = 2,
    parameter int IDW  = 2
) (
    input  logic                 resetn,
    input  logic                 SPI_Clk,
    input  logic                 SPI_CS,
    input  logic                 SPI_MOSI,
    input  logic [IDW-1:0]       IC_addr,
    output logic                 SPI_MISO,
    output logic                 SPI_MISO_oe,
    output logic [NREG*DW-1:0]   regs,
    output logic [AW-1:0]        wr_addr,
    output logic                 wr_toggle
);

    localparam int FRAME = 8 + DW;
    localparam int CW    = $clog2(FRAME + 1);
    localparam int IW    = $clog2(DW);

    localparam logic [CW-1:0] CNT_HDR   = CW'(7);
    localparam logic [CW-1:0] CNT_DATA0 = CW'(8);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME);
    // Data-phase bit index is (DW-1) - (cnt-8) = (DW+7) - cnt.
    localparam logic [CW-1:0] IDX_BASE  = CW'(DW + 7);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0]   cnt_q;
    logic [DW-2:0]   shift_q;
    logic [IDW-1:0]  hdr_ic_q;
    logic            hdr_rw_q;
    logic [AW-1:0]   hdr_addr_q;
    logic [DW-1:0]   rd_word_q;
    logic            rd_active_q;
    logic [DW-1:0]   regs_q [NREG];
    logic [AW-1:0]   wr_addr_q;
    logic            wr_toggle_q;
    logic            miso_q;

    // ------------------------------------------------------------------
    // Incoming word: previous shift contents plus the bit arriving now.
    // Its low byte is the header when cnt==7, and the whole word is the
    // register payload when cnt==8+DW-1.
    // ------------------------------------------------------------------
    logic [DW-1:0]   data_in;
    logic [IDW-1:0]  in_ic;
    logic            in_rw;
    logic [AW-1:0]   in_addr;

    assign data_in = {shift_q, SPI_MOSI};
    assign in_ic   = data_in[7 -: IDW];
    assign in_rw   = data_in[7-IDW];
    assign in_addr = data_in[AW-1:0];

    // Address is in range when it matches one of the implemented registers;
    // written as a match loop so NREG == 2**AW needs no special case.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (a == AW'(i)) v = 1'b1;
        end
        return v;
    endfunction

    // Read word captured at header time; out-of-range addresses read as 0.
    logic [DW-1:0] rd_word_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rd_word_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (in_addr == AW'(i)) rd_word_d = regs_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Frame state: counter, shifter, header latch, read setup.
    // Cleared asynchronously by reset or by SPI_CS going high, so an
    // aborted frame leaves nothing behind for the next one.
    // ------------------------------------------------------------------
    always_ff @(posedge SPI_Clk or negedge resetn or posedge SPI_CS) begin
        if (!resetn) begin
            // NOTE: sequential state is always assigned with <= so every
            // flop samples values from before the edge, regardless of order.
            cnt_q       <= '0;
            shift_q     <= '0;
            hdr_ic_q    <= '0;
            hdr_rw_q    <= 1'b0;
            hdr_addr_q  <= '0;
            rd_word_q   <= '0;
            rd_active_q <= 1'b0;
        end else if (SPI_CS) begin
            cnt_q       <= '0;
            shift_q     <= '0;
            hdr_ic_q    <= '0;
            hdr_rw_q    <= 1'b0;
            hdr_addr_q  <= '0;
            rd_word_q   <= '0;
            rd_active_q <= 1'b0;
        end else begin
            // Saturation stops both counting and shifting, so trailing bits
            // of an over-long frame cannot trigger a second commit.
            if (cnt_q != CNT_SAT) begin
                cnt_q   <= cnt_q + 1'b1;
                shift_q <= data_in[DW-2:0];
            end
            if (cnt_q == CNT_HDR) begin
                hdr_ic_q    <= in_ic;
                hdr_rw_q    <= in_rw;
                hdr_addr_q  <= in_addr;
                rd_word_q   <= rd_word_d;
                rd_active_q <= (in_ic == IC_addr) & in_rw;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file and write handshake. Only resetn clears these; a
    // CS abort must not disturb configuration already committed.
    // ------------------------------------------------------------------
    logic commit;

    assign commit = ~SPI_CS
                  & (cnt_q == CNT_LAST)
                  & (hdr_ic_q == IC_addr)
                  & ~hdr_rw_q
                  & addr_valid(hdr_addr_q);

    always_ff @(posedge SPI_Clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the register array is reset explicitly; these are
            // configuration flops with a defined power-up value, not RAM.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_addr_q   <= '0;
            wr_toggle_q <= 1'b0;
        end else if (commit) begin
            for (int i = 0; i < NREG; i++) begin
                if (hdr_addr_q == AW'(i)) regs_q[i] <= data_in;
            end
            wr_addr_q   <= hdr_addr_q;
            wr_toggle_q <= ~wr_toggle_q;
        end
    end

    // ------------------------------------------------------------------
    // MISO launch on the falling edge: the bit for data clock n is driven
    // half a cycle before the master samples it.
    // ------------------------------------------------------------------
    logic          miso_d;
    logic [IW-1:0] bit_idx;

    assign bit_idx = IW'(IDX_BASE - cnt_q);

    always_comb begin
        miso_d = 1'b0;
        if ((cnt_q >= CNT_DATA0) && (cnt_q < CNT_SAT)) begin
            miso_d = rd_word_q[bit_idx];
        end
    end

    always_ff @(negedge SPI_Clk or negedge resetn) begin
        if (!resetn) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= miso_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        regs = '0;
        for (int k = 0; k < NREG; k++) begin
            regs[k*DW +: DW] = regs_q[k];
        end
    end

    assign wr_addr     = wr_addr_q;
    assign wr_toggle   = wr_toggle_q;
    assign SPI_MISO    = miso_q;
    // The pad enable follows CS combinationally so the die releases the
    // line the moment the master deselects it.
    assign SPI_MISO_oe = ~SPI_CS & rd_active_q;

endmodule
